// File: rtl/ct_lsu_st_wb_cmplt_buf_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ct_lsu_st_wb_cmplt_buf_if                                       |
// | Purpose  : Bundle of the WMB push side, the WB arbiter request/grant side  |
// |            and the flush/status signals of the store write-back           |
// |            completion buffer.                                             |
// | Ports    : slave  - seen by the completion buffer                         |
// |            master - seen by the environment (WMB, WB arbiter, RTU)        |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface ct_lsu_st_wb_cmplt_buf_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // flush from the retire unit
  logic             rtu_yy_xx_flush;
  // WMB push side
  logic             wmb_cmplt_push;
  logic [6:0]       wmb_cmplt_push_iid;
  logic             wmb_cmplt_push_inst_flush;
  logic             wmb_cmplt_push_spec_fail;
  logic             wmb_cmplt_push_bkpta;
  logic             wmb_cmplt_push_bkptb;
  logic             cmplt_buf_full;
  // WB arbiter side
  logic             st_wb_wmb_cmplt_grnt;
  logic             wmb_st_wb_cmplt_req;
  logic [6:0]       wmb_st_wb_iid;
  logic             wmb_st_wb_inst_flush;
  logic             wmb_st_wb_spec_fail;
  logic             wmb_st_wb_bkpta_data;
  logic             wmb_st_wb_bkptb_data;
  // status
  logic             cmplt_buf_starve;
  logic [CNT_W-1:0] cmplt_buf_cnt;

  modport slave (
    input  rtu_yy_xx_flush,
    input  wmb_cmplt_push, wmb_cmplt_push_iid, wmb_cmplt_push_inst_flush,
    input  wmb_cmplt_push_spec_fail, wmb_cmplt_push_bkpta, wmb_cmplt_push_bkptb,
    output cmplt_buf_full,
    input  st_wb_wmb_cmplt_grnt,
    output wmb_st_wb_cmplt_req, wmb_st_wb_iid, wmb_st_wb_inst_flush,
    output wmb_st_wb_spec_fail, wmb_st_wb_bkpta_data, wmb_st_wb_bkptb_data,
    output cmplt_buf_starve, cmplt_buf_cnt
  );

  modport master (
    output rtu_yy_xx_flush,
    output wmb_cmplt_push, wmb_cmplt_push_iid, wmb_cmplt_push_inst_flush,
    output wmb_cmplt_push_spec_fail, wmb_cmplt_push_bkpta, wmb_cmplt_push_bkptb,
    input  cmplt_buf_full,
    output st_wb_wmb_cmplt_grnt,
    input  wmb_st_wb_cmplt_req, wmb_st_wb_iid, wmb_st_wb_inst_flush,
    input  wmb_st_wb_spec_fail, wmb_st_wb_bkpta_data, wmb_st_wb_bkptb_data,
    input  cmplt_buf_starve, cmplt_buf_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ct_lsu_st_wb_cmplt_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ct_lsu_st_wb_cmplt_buf                                          |
// | Purpose  : Circular FIFO of store-completion records between the WMB and  |
// |            the store write-back arbiter. Presents the head record as a    |
// |            request, pops on grant, and flags head starvation so the DA    |
// |            stage can be held off for a cycle.                             |
// | Ports    : forever_cpuclk - clock                                          |
// |            cpurst         - asynchronous active-high reset                |
// |            cmplt_if       - push / request / grant / status bundle        |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module ct_lsu_st_wb_cmplt_buf #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic                      forever_cpuclk,
  input  wire logic                      cpurst,
  ct_lsu_st_wb_cmplt_buf_if.slave        cmplt_if
);

  localparam int         c_PTR_W  = $clog2(DEPTH);
  localparam int         c_CNT_W  = c_PTR_W + 1;
  localparam int         c_REC_W  = 11;
  localparam logic [3:0] c_STARVE = 4'(STARVE_LIMIT);

  // entry layout: {iid[6:0], inst_flush, spec_fail, bkpta, bkptb}
  logic [c_REC_W-1:0] r_entry [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [3:0]         r_starve_cnt;
  logic [3:0]         w_starve_nxt;

  logic               w_full;
  logic               w_req;
  logic               w_flush;
  logic               w_push_acc;
  logic               w_pop;
  logic [c_REC_W-1:0] w_push_rec;
  logic [c_REC_W-1:0] w_head;

  assign w_flush    = cmplt_if.rtu_yy_xx_flush;
  // Full and req come from the registered count, so a pop in a full cycle
  // cannot make room for a push in that same cycle.
  assign w_full     = (r_cnt == c_CNT_W'(DEPTH));
  assign w_req      = (r_cnt != '0);
  assign w_push_acc = cmplt_if.wmb_cmplt_push && !w_full && !w_flush;
  assign w_pop      = cmplt_if.st_wb_wmb_cmplt_grnt && w_req && !w_flush;

  assign w_push_rec = {cmplt_if.wmb_cmplt_push_iid,
                       cmplt_if.wmb_cmplt_push_inst_flush,
                       cmplt_if.wmb_cmplt_push_spec_fail,
                       cmplt_if.wmb_cmplt_push_bkpta,
                       cmplt_if.wmb_cmplt_push_bkptb};

  // Record storage carries no reset: the head is gated by req, so stale
  // contents are never visible.
  always_ff @(posedge forever_cpuclk) begin
    if (w_push_acc) begin
      r_entry[r_wr_ptr] <= w_push_rec;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push_acc, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + c_CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - c_CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Starve count tracks consecutive denied cycles of the current head; any
  // grant while valid is a pop, so grant alone is enough to clear it.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!w_req || cmplt_if.st_wb_wmb_cmplt_grnt) begin
      w_starve_nxt = 4'd0;
    end else if (r_starve_cnt < c_STARVE) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_starve_cnt <= 4'd0;
    end else if (w_flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_starve_cnt <= 4'd0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      r_cnt        <= w_cnt_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  assign w_head = w_req ? r_entry[r_rd_ptr] : '0;

  assign cmplt_if.cmplt_buf_full       = w_full;
  assign cmplt_if.wmb_st_wb_cmplt_req  = w_req;
  assign cmplt_if.wmb_st_wb_iid        = w_head[10:4];
  assign cmplt_if.wmb_st_wb_inst_flush = w_head[3];
  assign cmplt_if.wmb_st_wb_spec_fail  = w_head[2];
  assign cmplt_if.wmb_st_wb_bkpta_data = w_head[1];
  assign cmplt_if.wmb_st_wb_bkptb_data = w_head[0];
  assign cmplt_if.cmplt_buf_starve     = (r_starve_cnt == c_STARVE) && w_req;
  assign cmplt_if.cmplt_buf_cnt        = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ct_lsu_st_wb_cmplt_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ct_lsu_st_wb_cmplt_buf                                       |
// | Purpose  : Self-checking bench for the store write-back completion buffer. |
// |            A queue-based reference model tracks expected contents; a      |
// |            negedge monitor compares every DUT output against it.          |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_ct_lsu_st_wb_cmplt_buf;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ct_lsu_st_wb_cmplt_buf_if #(.DEPTH(DEPTH)) bif();

  ct_lsu_st_wb_cmplt_buf #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .cmplt_if       (bif.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [10:0] q[$];       // expected contents, head first
  int          m_wait;     // consecutive cycles the head has been refused
  int          m_sz;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      m_wait = 0;
    end else if (bif.rtu_yy_xx_flush) begin
      q.delete();
      m_wait = 0;
    end else begin
      m_sz = q.size();
      if (m_sz != 0 && !bif.st_wb_wmb_cmplt_grnt)
        m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
      else
        m_wait = 0;
      if (bif.st_wb_wmb_cmplt_grnt && m_sz != 0) void'(q.pop_front());
      if (bif.wmb_cmplt_push && m_sz < DEPTH)
        q.push_back({bif.wmb_cmplt_push_iid, bif.wmb_cmplt_push_inst_flush,
                     bif.wmb_cmplt_push_spec_fail, bif.wmb_cmplt_push_bkpta,
                     bif.wmb_cmplt_push_bkptb});
    end
  end

  // ---------------- monitor ----------------
  logic [10:0] head;
  initial forever begin
    @(negedge clk);
    head = {bif.wmb_st_wb_iid, bif.wmb_st_wb_inst_flush, bif.wmb_st_wb_spec_fail,
            bif.wmb_st_wb_bkpta_data, bif.wmb_st_wb_bkptb_data};
    chk("cnt",    int'(bif.cmplt_buf_cnt),       q.size());
    chk("req",    int'(bif.wmb_st_wb_cmplt_req), int'(q.size() != 0));
    chk("full",   int'(bif.cmplt_buf_full),      int'(q.size() == DEPTH));
    chk("starve", int'(bif.cmplt_buf_starve),    int'(m_wait == LIMIT && q.size() != 0));
    if (q.size() != 0) chk("head_rec", int'(head), int'(q[0]));
    else               chk("head_idle", int'(head), 0);
  end

  // ---------------- driver ----------------
  task automatic step(input bit p, input logic [10:0] rec, input bit g, input bit f);
    bif.wmb_cmplt_push            = p;
    bif.wmb_cmplt_push_iid        = rec[10:4];
    bif.wmb_cmplt_push_inst_flush = rec[3];
    bif.wmb_cmplt_push_spec_fail  = rec[2];
    bif.wmb_cmplt_push_bkpta      = rec[1];
    bif.wmb_cmplt_push_bkptb      = rec[0];
    bif.st_wb_wmb_cmplt_grnt      = g;
    bif.rtu_yy_xx_flush           = f;
    @(posedge clk);
    #1;
  endtask

  int g_pct, p_pct;

  initial begin
    bif.wmb_cmplt_push            = 1'b0;
    bif.wmb_cmplt_push_iid        = 7'd0;
    bif.wmb_cmplt_push_inst_flush = 1'b0;
    bif.wmb_cmplt_push_spec_fail  = 1'b0;
    bif.wmb_cmplt_push_bkpta      = 1'b0;
    bif.wmb_cmplt_push_bkptb      = 1'b0;
    bif.st_wb_wmb_cmplt_grnt      = 1'b0;
    bif.rtu_yy_xx_flush           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",    int'(bif.wmb_st_wb_cmplt_req), 0);
    chk("rst_full",   int'(bif.cmplt_buf_full), 0);
    chk("rst_starve", int'(bif.cmplt_buf_starve), 0);
    chk("rst_cnt",    int'(bif.cmplt_buf_cnt), 0);
    chk("rst_iid",    int'(bif.wmb_st_wb_iid), 0);
    rst = 1'b0;

    // single push / grant
    step(1, {7'h15, 4'b0100}, 0, 0);
    chk("t1_req",  int'(bif.wmb_st_wb_cmplt_req), 1);
    chk("t1_iid",  int'(bif.wmb_st_wb_iid), 'h15);
    chk("t1_spec", int'(bif.wmb_st_wb_spec_fail), 1);
    step(0, 11'd0, 1, 0);
    chk("t1_req_after", int'(bif.wmb_st_wb_cmplt_req), 0);
    chk("t1_cnt_after", int'(bif.cmplt_buf_cnt), 0);

    // fill, dropped push, drain in order
    for (int i = 0; i < 4; i++) step(1, {7'(i + 1), 4'(i * 5)}, 0, 0);
    chk("t2_full", int'(bif.cmplt_buf_full), 1);
    chk("t2_cnt",  int'(bif.cmplt_buf_cnt), 4);
    step(1, {7'h7F, 4'hF}, 0, 0);
    chk("t2_cnt_drop", int'(bif.cmplt_buf_cnt), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", int'(bif.wmb_st_wb_iid), i + 1);
      step(0, 11'd0, 1, 0);
    end
    chk("t2_empty", int'(bif.cmplt_buf_cnt), 0);

    // wrap-around with simultaneous push/pop
    step(1, {7'h20, 4'b0000}, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("t3_iid", int'(bif.wmb_st_wb_iid), 'h20 + i);
      step(1, {7'(8'h21 + i), 4'(i)}, 1, 0);
      chk("t3_cnt", int'(bif.cmplt_buf_cnt), 1);
    end
    step(0, 11'd0, 1, 0);

    // starvation
    step(1, {7'h33, 4'b1001}, 0, 0);
    repeat (7) step(0, 11'd0, 0, 0);
    chk("t4_starve_7", int'(bif.cmplt_buf_starve), 0);
    step(0, 11'd0, 0, 0);
    chk("t4_starve_8", int'(bif.cmplt_buf_starve), 1);
    step(0, 11'd0, 0, 0);
    chk("t4_starve_sat", int'(bif.cmplt_buf_starve), 1);
    step(0, 11'd0, 1, 0);
    chk("t4_starve_clr", int'(bif.cmplt_buf_starve), 0);

    // flush with concurrent push
    for (int i = 0; i < 3; i++) step(1, {7'(8'h40 + i), 4'b0010}, 0, 0);
    step(1, {7'h55, 4'b1111}, 0, 1);
    chk("t5_cnt",    int'(bif.cmplt_buf_cnt), 0);
    chk("t5_req",    int'(bif.wmb_st_wb_cmplt_req), 0);
    chk("t5_starve", int'(bif.cmplt_buf_starve), 0);
    step(1, {7'h56, 4'b0001}, 0, 0);
    chk("t5_next_iid", int'(bif.wmb_st_wb_iid), 'h56);
    step(0, 11'd0, 1, 0);

    // asynchronous reset mid-operation
    step(1, {7'h61, 4'b0000}, 0, 0);
    step(1, {7'h62, 4'b0000}, 0, 0);
    bif.wmb_cmplt_push = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_req",    int'(bif.wmb_st_wb_cmplt_req), 0);
    chk("t6_cnt",    int'(bif.cmplt_buf_cnt), 0);
    chk("t6_full",   int'(bif.cmplt_buf_full), 0);
    chk("t6_starve", int'(bif.cmplt_buf_starve), 0);
    chk("t6_iid",    int'(bif.wmb_st_wb_iid), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, {7'h70, 4'b0100}, 0, 0);
    chk("t6_first_push", int'(bif.cmplt_buf_cnt), 1);

    // randomized traffic with varying pressure
    for (int blk = 0; blk < 40; blk++) begin
      case ($urandom_range(0, 3))
        0:       g_pct = 0;
        1:       g_pct = 20;
        2:       g_pct = 50;
        default: g_pct = 90;
      endcase
      p_pct = (int'($urandom_range(0, 2)) + 1) * 33;
      for (int c = 0; c < 50; c++)
        step($urandom_range(0, 99) < p_pct, 11'($urandom),
             $urandom_range(0, 99) < g_pct, $urandom_range(0, 99) < 2);
    end
    repeat (6) step(0, 11'd0, 1, 0);
    chk("final_cnt", int'(bif.cmplt_buf_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
